// File: rtl/spi_defs.sv
// Shared SPI definitions: FSM encodings, byte geometry and helpers used by
// both the SPI slave and the SPI master.
package spi_defs;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } spi_state_e;

    localparam int BYTE_W    = 8;
    localparam int MAX_BYTES = 4;

    // Saturate a requested byte count to the buffer depth.
    function automatic logic [2:0] clamp_count(input logic [2:0] cnt);
        if (cnt > 3'(MAX_BYTES)) begin
            return 3'(MAX_BYTES);
        end else begin
            return cnt;
        end
    endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Multi-flop synchronizer for one asynchronous SPI pin, with rise/fall
// detection against one extra registered copy of the synchronized level.
module spi_pin_sync
    import spi_defs::*;
#(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic pin_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    // Synchronizer chain and edge-detect history, preset to the pin's idle level.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_sync <= {SYNC_STAGES{RESET_VAL}};
            r_prev <= RESET_VAL;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], pin_i};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign sync_o = r_sync[SYNC_STAGES-1];
    assign rise_o = r_sync[SYNC_STAGES-1] & ~r_prev;
    assign fall_o = ~r_sync[SYNC_STAGES-1] & r_prev;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 slave: MSB-first byte shifting, 4-byte receive buffer with
// sticky overflow, and a snapshot of up to 4 reply bytes per burst.
module spi_slave
    import spi_defs::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        spi_clk_i,
    input  logic        spi_mosi_i,
    input  logic        spi_ss_n_i,
    output logic        spi_miso_o,
    input  logic [31:0] tx_data_i,
    input  logic [2:0]  tx_data_bytes_valid_i,
    input  logic        reset_fill_level_i,
    output logic [31:0] rx_data_o,
    output logic [2:0]  rx_data_bytes_valid_o,
    output logic        busy_o,
    output logic        overflow_o
);

    spi_state_e  r_state;
    spi_state_e  w_next_state;
    logic        w_sclk_rise, w_sclk_fall, w_unused_sclk_lvl;
    logic        w_mosi, w_unused_mosi_rise, w_unused_mosi_fall;
    logic        w_ss_rise, w_ss_fall, w_unused_ss_lvl;
    logic [31:0] r_tx_snap;
    logic [2:0]  r_tx_cnt;
    logic [2:0]  r_tx_idx;
    logic [7:0]  r_tx;
    logic [7:0]  w_tx_next;
    logic [2:0]  r_bit_cnt;
    logic [6:0]  r_rx_shift;
    logic [7:0]  w_rx_byte;
    logic        w_shift_en;
    logic        w_byte_done;
    logic [31:0] r_rx_data;
    logic [2:0]  r_fill;
    logic        r_overflow;

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk_i(clk_i), .rstn_i(rstn_i), .pin_i(spi_clk_i),
        .sync_o(w_unused_sclk_lvl), .rise_o(w_sclk_rise), .fall_o(w_sclk_fall)
    );

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk_i(clk_i), .rstn_i(rstn_i), .pin_i(spi_mosi_i),
        .sync_o(w_mosi), .rise_o(w_unused_mosi_rise), .fall_o(w_unused_mosi_fall)
    );

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
        .clk_i(clk_i), .rstn_i(rstn_i), .pin_i(spi_ss_n_i),
        .sync_o(w_unused_ss_lvl), .rise_o(w_ss_rise), .fall_o(w_ss_fall)
    );

    // State register.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Transaction framing follows the synchronized slave-select edges only.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_ss_fall) w_next_state = ST_ACTIVE;
                else           w_next_state = ST_IDLE;
            end
            ST_ACTIVE: begin
                if (w_ss_rise) w_next_state = ST_IDLE;
                else           w_next_state = ST_ACTIVE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Next reply byte, or zero once past the snapshot count.
    always_comb begin
        w_tx_next = 8'h00;
        if (r_tx_idx < r_tx_cnt) begin
            w_tx_next = r_tx_snap[{r_tx_idx[1:0], 3'b000} +: 8];
        end else begin
            w_tx_next = 8'h00;
        end
    end

    assign w_shift_en  = (r_state == ST_ACTIVE) && !w_ss_rise;
    assign w_rx_byte   = {r_rx_shift, w_mosi};
    assign w_byte_done = w_shift_en && w_sclk_rise && (r_bit_cnt == 3'd7);

    // Bit-level shifting in both directions plus burst-start snapshot.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_tx_snap  <= 32'h0000_0000;
            r_tx_cnt   <= 3'd0;
            r_tx_idx   <= 3'd0;
            r_tx       <= 8'h00;
            r_bit_cnt  <= 3'd0;
            r_rx_shift <= 7'd0;
        end else if ((r_state == ST_IDLE) && w_ss_fall) begin
            r_tx_snap  <= tx_data_i;
            r_tx_cnt   <= clamp_count(tx_data_bytes_valid_i);
            r_tx_idx   <= 3'd1;
            r_tx       <= (clamp_count(tx_data_bytes_valid_i) == 3'd0) ? 8'h00 : tx_data_i[7:0];
            r_bit_cnt  <= 3'd0;
            r_rx_shift <= 7'd0;
        end else if (w_shift_en) begin
            if (w_sclk_rise) begin
                r_rx_shift <= w_rx_byte[6:0];
                r_bit_cnt  <= r_bit_cnt + 3'd1;
            end
            // A falling edge with the counter back at 0 ends a full byte.
            if (w_sclk_fall) begin
                if (r_bit_cnt == 3'd0) begin
                    r_tx     <= w_tx_next;
                    r_tx_idx <= (r_tx_idx < 3'(MAX_BYTES)) ? r_tx_idx + 3'd1 : r_tx_idx;
                end else begin
                    r_tx <= {r_tx[6:0], 1'b0};
                end
            end
        end
    end

    // Receive buffer: fill level, byte slots and sticky overflow.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_rx_data  <= 32'h0000_0000;
            r_fill     <= 3'd0;
            r_overflow <= 1'b0;
        end else if (w_byte_done) begin
            if (reset_fill_level_i) begin
                r_rx_data[7:0] <= w_rx_byte;
                r_fill         <= 3'd1;
                r_overflow     <= 1'b0;
            end else if (r_fill >= 3'(MAX_BYTES)) begin
                r_overflow <= 1'b1;
            end else begin
                r_rx_data[{r_fill[1:0], 3'b000} +: 8] <= w_rx_byte;
                r_fill <= r_fill + 3'd1;
            end
        end else if (reset_fill_level_i) begin
            r_fill     <= 3'd0;
            r_overflow <= 1'b0;
        end
    end

    assign rx_data_o             = r_rx_data;
    assign rx_data_bytes_valid_o = r_fill;
    assign overflow_o            = r_overflow;
    assign busy_o                = (r_state == ST_ACTIVE);
    assign spi_miso_o            = (r_state == ST_ACTIVE) & r_tx[7];

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a bit-banged mode-0 master drives bursts while
// a monitor compares each receive-buffer change against a queue of expected states.
module tb_spi_slave;
    import spi_defs::*;

    logic        clk_i = 1'b0;
    logic        rstn_i = 1'b0;
    logic        spi_clk_i = 1'b0;
    logic        spi_mosi_i = 1'b0;
    logic        spi_ss_n_i = 1'b1;
    logic        spi_miso_o;
    logic [31:0] tx_data_i = 32'h0;
    logic [2:0]  tx_data_bytes_valid_i = 3'd0;
    logic        reset_fill_level_i = 1'b0;
    logic [31:0] rx_data_o;
    logic [2:0]  rx_data_bytes_valid_o;
    logic        busy_o;
    logic        overflow_o;

    spi_slave #(.SYNC_STAGES(2)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .spi_clk_i(spi_clk_i), .spi_mosi_i(spi_mosi_i), .spi_ss_n_i(spi_ss_n_i),
        .spi_miso_o(spi_miso_o),
        .tx_data_i(tx_data_i), .tx_data_bytes_valid_i(tx_data_bytes_valid_i),
        .reset_fill_level_i(reset_fill_level_i),
        .rx_data_o(rx_data_o), .rx_data_bytes_valid_o(rx_data_bytes_valid_o),
        .busy_o(busy_o), .overflow_o(overflow_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [2:0]  fill;
        logic        ovf;
        logic [31:0] data;
    } rx_state_t;

    rx_state_t exp_q[$];
    rx_state_t mon_prev = '0;
    rx_state_t mon_cur;
    rx_state_t mon_exp;
    bit        mon_en = 1'b0;
    int        checks = 0;
    int        failures = 0;

    task automatic tick(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [2:0] fill, input logic ovf, input logic [31:0] data);
        rx_state_t e;
        e.fill = fill;
        e.ovf  = ovf;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Monitor: every change of the receive-side outputs must match the next expected state.
    always @(negedge clk_i) begin
        if (mon_en) begin
            mon_cur = {rx_data_bytes_valid_o, overflow_o, rx_data_o};
            if (mon_cur !== mon_prev) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL rx_unexpected: got fill=%0d ovf=%0d data=0x%08h expected no change",
                             mon_cur.fill, mon_cur.ovf, mon_cur.data);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (mon_cur !== mon_exp) begin
                        failures++;
                        $display("FAIL rx_state: got fill=%0d ovf=%0d data=0x%08h expected fill=%0d ovf=%0d data=0x%08h",
                                 mon_cur.fill, mon_cur.ovf, mon_cur.data,
                                 mon_exp.fill, mon_exp.ovf, mon_exp.data);
                    end
                end
                mon_prev = mon_cur;
            end
        end
    end

    task automatic ss_low();
        spi_ss_n_i = 1'b0;
        tick(8);
    endtask

    task automatic ss_high();
        tick(4);
        spi_ss_n_i = 1'b1;
        tick(8);
    endtask

    // Mode-0 master: nbits MSB-first at clk/8, MISO sampled just before each rising edge.
    task automatic spi_byte(input logic [7:0] b, input int nbits, input logic [7:0] exp_miso,
                            input bit chk, input bit pulse_last, input string name);
        logic [7:0] got;
        got = 8'h00;
        for (int i = 7; i >= 8 - nbits; i--) begin
            spi_mosi_i = b[i];
            tick(4);
            got = {got[6:0], spi_miso_o};
            spi_clk_i = 1'b1;
            if (pulse_last && (i == 0)) begin
                tick(2);
                reset_fill_level_i = 1'b1;
                tick(1);
                reset_fill_level_i = 1'b0;
                tick(1);
            end else begin
                tick(4);
            end
            spi_clk_i = 1'b0;
        end
        if (chk) check(name, {24'h0, got}, {24'h0, exp_miso});
    endtask

    task automatic fill_reset_pulse();
        reset_fill_level_i = 1'b1;
        tick(1);
        reset_fill_level_i = 1'b0;
        tick(4);
    endtask

    initial begin
        logic [7:0] t2_bytes [5];
        t2_bytes[0] = 8'h11; t2_bytes[1] = 8'h22; t2_bytes[2] = 8'h33;
        t2_bytes[3] = 8'h44; t2_bytes[4] = 8'h55;

        // Reset values
        rstn_i = 1'b0;
        tick(4);
        check("rst_rx_data", rx_data_o, 32'h0);
        check("rst_fill", {29'h0, rx_data_bytes_valid_o}, 32'h0);
        check("rst_miso", {31'h0, spi_miso_o}, 32'h0);
        check("rst_busy", {31'h0, busy_o}, 32'h0);
        check("rst_ovf", {31'h0, overflow_o}, 32'h0);
        rstn_i = 1'b1;
        tick(4);
        mon_en = 1'b1;

        // Basic two-byte exchange
        tx_data_i = 32'hDDCCBBAA;
        tx_data_bytes_valid_i = 3'd2;
        push_exp(3'd1, 1'b0, 32'h0000003C);
        push_exp(3'd2, 1'b0, 32'h0000813C);
        ss_low();
        check("t1_busy_active", {31'h0, busy_o}, 32'h1);
        spi_byte(8'h3C, 8, 8'hAA, 1'b1, 1'b0, "t1_miso_b0");
        spi_byte(8'h81, 8, 8'hBB, 1'b1, 1'b0, "t1_miso_b1");
        ss_high();
        check("t1_busy_idle", {31'h0, busy_o}, 32'h0);
        check("t1_miso_idle", {31'h0, spi_miso_o}, 32'h0);
        push_exp(3'd0, 1'b0, 32'h0000813C);
        fill_reset_pulse();

        // Overflow on the fifth byte; reply count 0 gives all-zero MISO
        tx_data_i = 32'hFFFFFFFF;
        tx_data_bytes_valid_i = 3'd0;
        push_exp(3'd1, 1'b0, 32'h00008111);
        push_exp(3'd2, 1'b0, 32'h00002211);
        push_exp(3'd3, 1'b0, 32'h00332211);
        push_exp(3'd4, 1'b0, 32'h44332211);
        push_exp(3'd4, 1'b1, 32'h44332211);
        ss_low();
        for (int k = 0; k < 5; k++) begin
            spi_byte(t2_bytes[k], 8, 8'h00, 1'b1, 1'b0, $sformatf("t2_miso_b%0d", k));
        end
        ss_high();
        push_exp(3'd0, 1'b0, 32'h44332211);
        fill_reset_pulse();

        // Aborted partial byte, then a full byte; count 7 clamps to 4
        ss_low();
        spi_byte(8'hE8, 5, 8'h00, 1'b0, 1'b0, "t3_partial");
        ss_high();
        tx_data_i = 32'h12345678;
        tx_data_bytes_valid_i = 3'd7;
        push_exp(3'd1, 1'b0, 32'h44332255);
        ss_low();
        spi_byte(8'h55, 8, 8'h78, 1'b1, 1'b0, "t3_miso_b0");
        ss_high();

        // Fill reset coinciding with byte completion at fill 3; count 1 then zeros
        tx_data_i = 32'hAABBCC11;
        tx_data_bytes_valid_i = 3'd1;
        push_exp(3'd2, 1'b0, 32'h44330155);
        push_exp(3'd3, 1'b0, 32'h44020155);
        push_exp(3'd1, 1'b0, 32'h440201A5);
        ss_low();
        spi_byte(8'h01, 8, 8'h11, 1'b1, 1'b0, "t4_miso_b0");
        spi_byte(8'h02, 8, 8'h00, 1'b1, 1'b0, "t4_miso_b1");
        spi_byte(8'hA5, 8, 8'h00, 1'b1, 1'b1, "t4_miso_b2");
        ss_high();

        // Reset mid-byte aborts the burst
        ss_low();
        spi_byte(8'hF0, 4, 8'h00, 1'b0, 1'b0, "t5_partial");
        push_exp(3'd0, 1'b0, 32'h00000000);
        rstn_i = 1'b0;
        tick(2);
        check("t5_rst_busy", {31'h0, busy_o}, 32'h0);
        check("t5_rst_miso", {31'h0, spi_miso_o}, 32'h0);
        spi_ss_n_i = 1'b1;
        spi_clk_i = 1'b0;
        tick(3);
        rstn_i = 1'b1;
        tick(6);
        check("t5_post_rst_busy", {31'h0, busy_o}, 32'h0);
        // SCLK activity while deselected must be ignored
        for (int k = 0; k < 8; k++) begin
            spi_mosi_i = 1'b1;
            spi_clk_i = 1'b1;
            tick(4);
            spi_clk_i = 1'b0;
            tick(4);
        end
        tx_data_i = 32'h000000C3;
        tx_data_bytes_valid_i = 3'd1;
        push_exp(3'd1, 1'b0, 32'h0000000F);
        ss_low();
        spi_byte(8'h0F, 8, 8'hC3, 1'b1, 1'b0, "t5_miso_b0");
        ss_high();

        // All expected receive events must have been seen
        for (int k = 0; k < 200 && exp_q.size() != 0; k++) tick(1);
        tick(10);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: flops per pin synchronizer, minimum 2.
REQ-002 SHALL have port clk_i  input  1  system clock; all logic in this single domain.
REQ-003 SHALL have port rstn_i  input  1  reset; reset is synchronous and active-low.
REQ-004 SHALL have ports spi_clk_i, spi_mosi_i, spi_ss_n_i  input  1 each  asynchronous SPI pins.
REQ-005 SHALL have port spi_miso_o  output  1  serial data to master; always driven, no tristate.
REQ-006 SHALL have port tx_data_i  input  32  reply bytes; byte k is bits [8k+7:8k].
REQ-007 SHALL have port tx_data_bytes_valid_i  input  3  count of valid reply bytes; values above 4 are treated as 4.
REQ-008 SHALL have port reset_fill_level_i  input  1  one-cycle pulse that empties the receive buffer.
REQ-009 SHALL have port rx_data_o  output  32  received bytes; first byte of a burst in [7:0].
REQ-010 SHALL have port rx_data_bytes_valid_o  output  3  receive fill level, 0..4.
REQ-011 SHALL have ports busy_o and overflow_o  output  1 each  transaction active; sticky overflow flag.

Function
REQ-012 SHALL use SPI mode 0, MSB first: sample MOSI on SCLK rising edge; update MISO on SCLK falling edge.
REQ-013 SHALL pass spi_clk_i, spi_mosi_i and spi_ss_n_i through SYNC_STAGES flops, then detect SCLK and SS edges from one extra registered copy.
REQ-014 SHALL support SCLK up to clk_i/8; faster SCLK is outside specification.
REQ-015 SHALL implement the FSM IDLE -> ACTIVE on synchronized SS falling edge, and ACTIVE -> IDLE on SS rising edge; no other transitions exist.
REQ-016 On entering ACTIVE, SHALL snapshot tx_data_i and tx_data_bytes_valid_i, clear the bit and tx byte counters, and load tx byte 0.
REQ-017 If the tx valid count is 0, SHALL load 0x00 instead of tx byte 0; busy_o SHALL be 1 exactly while in ACTIVE.
REQ-018 On each SCLK rising edge in ACTIVE, SHALL shift the synchronized MOSI into the rx shift register LSB and increment the 3-bit bit counter.
REQ-019 When the bit counter wraps 7->0, SHALL write the rx byte into slot rx_data_bytes_valid_o of rx_data_o and increment the fill level, in the same clk_i cycle.
REQ-020 If the fill level is already 4 at byte completion, SHALL drop the byte, hold rx_data_o, and set overflow_o.
REQ-021 On each SCLK falling edge in ACTIVE, SHALL shift the tx register left so MISO presents the next bit.
REQ-022 After the 8th bit of a byte, SHALL instead load the next tx byte, or 0x00 once the byte index is at or above the snapshot valid count.
REQ-023 SHALL drive spi_miso_o from the tx register MSB in ACTIVE and 0 in IDLE.
REQ-024 On SS rising edge mid-byte, SHALL discard the partial byte and leave the fill level unchanged.
REQ-025 SHALL ignore SCLK edges in IDLE.
REQ-026 reset_fill_level_i SHALL set the fill level to 0 and clear overflow_o; rx_data_o contents are not cleared.
REQ-027 If reset_fill_level_i coincides with byte completion, SHALL write the new byte to slot 0 and set the fill level to 1.
REQ-028 rx_data_bytes_valid_o SHALL update SYNC_STAGES+1 clk_i cycles after the 8th SCLK rising edge at the pin.

Reset
REQ-029 On rstn_i low at a clk_i edge, SHALL enter IDLE and clear all counters and shift registers.
REQ-030 Under reset, SHALL output rx_data_o=0, rx_data_bytes_valid_o=0, spi_miso_o=0, busy_o=0, overflow_o=0.
REQ-031 SHALL preset synchronizers to SCLK=0, SS_n=1, MOSI=0, so that reset release produces no false edge.
REQ-032 Reset asserted mid-transaction SHALL abort it; the slave SHALL wait for a fresh SS falling edge.

Structure
REQ-033 SHALL place the FSM state encodings, byte width (8) and max byte count (4) in the shared spi_defs package/header, also used by the SPI master.
REQ-034 SHALL instantiate one sub-module, spi_pin_sync: a SYNC_STAGES synchronizer plus rise/fall detect, used once per SPI input.

Verification
REQ-035 Reset, tx=0xDDCCBBAA with count 2, master sends 0x3C,0x81 at clk/8 -> rx_data_o[15:0]=0x813C, fill=2; MISO bytes 0xAA,0xBB.
REQ-036 Master sends 5 bytes with no fill reset -> fill=4, overflow_o=1, rx_data_o holds the first 4 bytes.
REQ-037 SS deasserted after 5 bits, then a new byte 0x55 -> fill=1, rx_data_o[7:0]=0x55.
REQ-038 reset_fill_level_i pulsed in the same cycle as completion of byte 0xA5 at fill=3 -> fill=1, rx_data_o[7:0]=0xA5, overflow_o=0.
REQ-039 tx count 0, 1-byte burst -> MISO all zeros; tx count 1, 3-byte burst -> tx byte 0 then 0x00, 0x00.
REQ-040 rstn_i low at bit 4 of a byte, released, then a full byte 0x0F -> fill=1, rx_data_o[7:0]=0x0F; no byte from the aborted burst.
